// File: rtl/wb32_sram_slave.sv
// Wishbone classic 32-bit slave in front of a single-port word RAM with byte lanes and fixed wait states.
// Define WB32_SRAM_SLAVE_ERR_EN to answer out-of-range addresses with wb_err_o instead of aliasing.
// state  | meaning
// IDLE   | waiting for cyc & stb
// WAIT   | counting wait states, abort if the master lets go
// RESP   | one-cycle ack/err, strobe ignored
module wb32_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_err_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] W_LOAD = 4'(WAIT_STATES);

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_we;
    logic [3:0]            r_sel;
    logic [31:0]           r_wdat;
    logic                  r_bad;
    logic                  r_ack;
    logic                  r_err;
    logic [31:0]           r_dat;
    logic [31:0]           r_mem [0:(1<<ADDR_WIDTH)-1];

    logic                  w_req;
    logic                  w_adr_bad;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_we;
    logic [3:0]            w_sel;
    logic [31:0]           w_wdat;
    logic                  w_bad;
    logic                  w_unused;

    assign w_req = wb_cyc_i & wb_stb_i;

`ifdef WB32_SRAM_SLAVE_ERR_EN
    assign w_adr_bad = |wb_adr_i[31:ADDR_WIDTH+2];
`else
    assign w_adr_bad = 1'b0;
`endif
    assign w_unused = &{1'b0, wb_adr_i[1:0], wb_adr_i[31:ADDR_WIDTH+2]};

    // With zero wait states the commit happens on the sampling edge, so take the live bus fields.
    assign w_idx  = (r_state == S_IDLE) ? wb_adr_i[ADDR_WIDTH+1:2] : r_idx;
    assign w_we   = (r_state == S_IDLE) ? wb_we_i   : r_we;
    assign w_sel  = (r_state == S_IDLE) ? wb_sel_i  : r_sel;
    assign w_wdat = (r_state == S_IDLE) ? wb_dat_i  : r_wdat;
    assign w_bad  = (r_state == S_IDLE) ? w_adr_bad : r_bad;

    always_comb begin
        w_commit = 1'b0;
        case (r_state)
            S_IDLE:  w_commit = w_req && (WAIT_STATES == 0);
            S_WAIT:  w_commit = w_req && (r_cnt == 4'd1);
            default: w_commit = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_sel   <= 4'd0;
            r_wdat  <= 32'd0;
            r_bad   <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= 32'd0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx  <= wb_adr_i[ADDR_WIDTH+1:2];
                        r_we   <= wb_we_i;
                        r_sel  <= wb_sel_i;
                        r_wdat <= wb_dat_i;
                        r_bad  <= w_adr_bad;
                        r_cnt  <= W_LOAD;
                        r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!w_req) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) r_state <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_commit) begin
                r_ack <= !w_bad;
                r_err <= w_bad;
                if (!w_we && !w_bad) r_dat <= r_mem[w_idx];
            end
        end
    end

    // Memory is deliberately left out of reset; only the commit is gated by it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_ni && w_commit && w_we && !w_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (w_sel[i]) r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
            end
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_dat_o = r_dat;
endmodule
